// File: rtl/calc_text_renderer.sv
`timescale 1ns/1ps
// calc_text_renderer: one line of scaled 8x8 text. Holds a line buffer of
// ASCII codes, drives the font ROM lookup and turns the returned font row
// into RGB444 pixels, three clocks after the coordinate arrives.
module calc_text_renderer #(
  parameter int unsigned COLS       = 16,
  parameter int unsigned X0         = 0,
  parameter int unsigned Y0         = 0,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter logic [11:0] FG         = 12'hFFF,
  parameter logic [11:0] BG         = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [7:0]  wr_char,
  input  logic        clear,
  output logic [7:0]  char_code,
  output logic [3:0]  row,
  input  logic [7:0]  font_line,
  output logic        pixel_on,
  output logic [11:0] rgb
);

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned GLYPH_W = 8 << SCALE_LOG2;
  localparam int unsigned BOX_W   = COLS * GLYPH_W;
  localparam logic [CHAR_W-1:0] SPACE = 8'd32;

  logic [CHAR_W-1:0]  buf_q [COLS];

  logic [COORD_W-1:0] lx_c;
  logic [COORD_W-1:0] ly_c;
  logic [COORD_W-1:0] col_c;
  logic [2:0]         grow_c;
  logic [2:0]         gbit_c;
  logic               in_box_c;
  logic [CHAR_W-1:0]  rd_char_c;

  logic [2:0]         gbit_d1, gbit_d2;
  logic               in_box_d1, in_box_d2;
  logic               video_on_d1, video_on_d2;
  logic               lit_c;

  // Line buffer: clear wins over a write; out-of-range addresses match no entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < COLS; i++) buf_q[i] <= SPACE;
    end else if (clear) begin
      for (int unsigned i = 0; i < COLS; i++) buf_q[i] <= SPACE;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < COLS; i++)
        if (wr_addr == 6'(i)) buf_q[i] <= wr_char;
    end
  end

  // Stage 0: box-relative coordinates; lx/ly wrap below the origin but in_box masks that
  always_comb begin
    lx_c     = pixel_x - COORD_W'(X0);
    ly_c     = pixel_y - COORD_W'(Y0);
    col_c    = lx_c >> (3 + SCALE_LOG2);
    grow_c   = 3'(ly_c >> SCALE_LOG2);
    gbit_c   = 3'(lx_c >> SCALE_LOG2);
    in_box_c = (32'(pixel_x) >= X0) && (32'(pixel_x) < X0 + BOX_W) &&
               (32'(pixel_y) >= Y0) && (32'(pixel_y) < Y0 + GLYPH_W) &&
               video_on;
  end

  // Buffer read mux; columns past COLS read as space
  always_comb begin
    rd_char_c = SPACE;
    for (int unsigned i = 0; i < COLS; i++)
      if (col_c == COORD_W'(i)) rd_char_c = buf_q[i];
  end

  // Stage 1: glyph lookup to the font ROM, non-ASCII codes shown as space
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code   <= SPACE;
      row         <= 4'd0;
      gbit_d1     <= 3'd0;
      in_box_d1   <= 1'b0;
      video_on_d1 <= 1'b0;
    end else begin
      char_code   <= (in_box_c && !rd_char_c[7]) ? rd_char_c : SPACE;
      row         <= {1'b0, grow_c};
      gbit_d1     <= gbit_c;
      in_box_d1   <= in_box_c;
      video_on_d1 <= video_on;
    end
  end

  // Stage 2: align pixel flags with the ROM's one-cycle read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gbit_d2     <= 3'd0;
      in_box_d2   <= 1'b0;
      video_on_d2 <= 1'b0;
    end else begin
      gbit_d2     <= gbit_d1;
      in_box_d2   <= in_box_d1;
      video_on_d2 <= video_on_d1;
    end
  end

  // Bit 7 of the font row is the leftmost pixel, so bit index is 7 - gbit
  assign lit_c = in_box_d2 & font_line[~gbit_d2];

  // Stage 3: registered colour output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on <= 1'b0;
      rgb      <= RGB_W'(0);
    end else begin
      pixel_on <= lit_c;
      rgb      <= lit_c ? FG : (video_on_d2 ? BG : RGB_W'(0));
    end
  end

endmodule

// File: tb/tb_calc_text_renderer.sv
`timescale 1ns/1ps
// Scoreboard bench for calc_text_renderer: directed pixels push hand-computed
// expectations; a monitor pops them at the lookup (1 clk) and pixel (3 clk) taps.
module tb_calc_text_renderer;

  localparam logic [11:0] FG_C = 12'hFFF;
  localparam logic [11:0] BG_C = 12'h00F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        video_on = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [7:0]  wr_char = '0;
  logic        clear = 1'b0;
  logic [7:0]  char_code;
  logic [3:0]  row;
  logic [7:0]  font_line = '0;
  logic        pixel_on;
  logic [11:0] rgb;

  calc_text_renderer #(
    .COLS(16), .X0(0), .Y0(0), .SCALE_LOG2(2), .FG(FG_C), .BG(BG_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .clear(clear), .char_code(char_code), .row(row), .font_line(font_line),
    .pixel_on(pixel_on), .rgb(rgb)
  );

  always #5 clk = ~clk;

  // Font ROM model: one-cycle registered read
  function automatic logic [7:0] rom(input logic [7:0] c, input logic [3:0] r);
    case (c)
      8'd49:   rom = 8'b00011000;
      8'd43:   rom = (r == 4'd3) ? 8'hFF : 8'h10;
      8'd65:   rom = 8'h01;
      default: rom = 8'h00;
    endcase
  endfunction

  always @(posedge clk) font_line <= rom(char_code, row);

  typedef struct { logic [7:0] code; logic [3:0] r; } lk_t;
  typedef struct { logic on; logic [11:0] c; } px_t;

  lk_t lq[$];
  px_t pq[$];
  lk_t lk_e;
  px_t px_e;
  logic       stim_v = 1'b0;
  logic [2:0] vsr;
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Tracks which output cycles carry a scored pixel
  always @(posedge clk or negedge rst_n)
    if (!rst_n) vsr <= 3'b000;
    else        vsr <= {vsr[1:0], stim_v};

  // Monitor: compare lookup one clock and colour three clocks after issue
  always @(negedge clk) begin
    if (vsr[0]) begin
      if (lq.size() == 0) chk("lookup_queue_empty", 1, 0);
      else begin
        lk_e = lq.pop_front();
        chk("char_code", int'(char_code), int'(lk_e.code));
        chk("row", int'(row), int'(lk_e.r));
      end
    end
    if (vsr[2]) begin
      if (pq.size() == 0) chk("pixel_queue_empty", 1, 0);
      else begin
        px_e = pq.pop_front();
        chk("pixel_on", int'(pixel_on), int'(px_e.on));
        chk("rgb", int'(rgb), int'(px_e.c));
      end
    end
  end

  task automatic drive(input int x, input int y, input logic von,
                       input logic we, input int wa, input int wc, input logic clr,
                       input logic sc, input logic [7:0] ec, input logic [3:0] er,
                       input logic eo, input logic [11:0] erg);
    @(negedge clk); #1;
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
    wr_en = we; wr_addr = 6'(wa); wr_char = 8'(wc); clear = clr;
    stim_v = sc;
    if (sc) begin
      lq.push_back('{code: ec, r: er});
      pq.push_back('{on: eo, c: erg});
    end
  endtask

  task automatic pix(input int x, input int y, input logic von,
                     input logic [7:0] ec, input logic [3:0] er,
                     input logic eo, input logic [11:0] erg);
    drive(x, y, von, 1'b0, 0, 0, 1'b0, 1'b1, ec, er, eo, erg);
  endtask

  task automatic wr(input int a, input int c, input logic clr);
    drive(0, 0, 1'b0, 1'b1, a, c, clr, 1'b0, 8'd0, 4'd0, 1'b0, 12'h0);
  endtask

  task automatic drain();
    drive(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 12'h0);
    for (int i = 0; i < 10 && (lq.size() != 0 || pq.size() != 0); i++) @(negedge clk);
    chk("drain", lq.size() + pq.size(), 0);
    lq.delete();
    pq.delete();
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 31));
      video_on = 1'($urandom); wr_en = 1'($urandom); wr_addr = 6'($urandom);
      wr_char = 8'($urandom); clear = 1'($urandom);
      @(negedge clk);
      chk("reset_rgb", int'(rgb), 0);
      chk("reset_pixel_on", int'(pixel_on), 0);
      chk("reset_char_code", int'(char_code), 32);
    end
    @(negedge clk); #1;
    pixel_x = '0; pixel_y = '0; video_on = 1'b0; wr_en = 1'b0; clear = 1'b0;
    rst_n = 1'b1;

    // Visible line sweep after reset: spaces everywhere
    for (int x = 0; x < 640; x++) pix(x, 0, 1'b1, 8'd32, 4'd0, 1'b0, BG_C);
    drain();

    // '1' in column 0: gbit 3 lit, gbit 1 dark, gbit 4 lit
    wr(0, 49, 1'b0);
    pix(12, 0, 1'b1, 8'd49, 4'd0, 1'b1, FG_C);
    pix(4,  0, 1'b1, 8'd49, 4'd0, 1'b0, BG_C);
    pix(16, 0, 1'b1, 8'd49, 4'd0, 1'b1, FG_C);

    // '+' in column 3: row decode
    wr(3, 43, 1'b0);
    pix(96,  13, 1'b1, 8'd43, 4'd3, 1'b1, FG_C);
    pix(96,  5,  1'b1, 8'd43, 4'd1, 1'b0, BG_C);
    pix(108, 5,  1'b1, 8'd43, 4'd1, 1'b1, FG_C);

    // Box edges and blanking
    wr(15, 65, 1'b0);
    pix(511, 0,  1'b1, 8'd65, 4'd0, 1'b1, FG_C);
    pix(512, 0,  1'b1, 8'd32, 4'd0, 1'b0, BG_C);
    pix(12,  0,  1'b0, 8'd32, 4'd0, 1'b0, 12'h000);
    pix(12,  32, 1'b1, 8'd32, 4'd0, 1'b0, BG_C);
    pix(639, 31, 1'b1, 8'd32, 4'd7, 1'b0, BG_C);
    pix(511, 31, 1'b1, 8'd65, 4'd7, 1'b1, FG_C);

    // Same-cycle write and lookup: old value first, new value next
    drive(12, 0, 1'b1, 1'b1, 0, 65, 1'b0, 1'b1, 8'd49, 4'd0, 1'b1, FG_C);
    pix(12, 0, 1'b1, 8'd65, 4'd0, 1'b0, BG_C);
    pix(40, 0, 1'b1, 8'd32, 4'd0, 1'b0, BG_C);

    // clear beats wr_en
    wr(1, 65, 1'b1);
    pix(12,  0,  1'b1, 8'd32, 4'd0, 1'b0, BG_C);
    pix(44,  0,  1'b1, 8'd32, 4'd0, 1'b0, BG_C);
    pix(96,  13, 1'b1, 8'd32, 4'd3, 1'b0, BG_C);
    pix(511, 0,  1'b1, 8'd32, 4'd0, 1'b0, BG_C);

    // Out-of-range addresses ignored
    wr(20, 49, 1'b0);
    wr(16, 49, 1'b0);
    pix(140, 0, 1'b1, 8'd32, 4'd0, 1'b0, BG_C);
    pix(12,  0, 1'b1, 8'd32, 4'd0, 1'b0, BG_C);

    // Codes above 127 shown as space; 127 passes through
    wr(2, 200, 1'b0);
    pix(76, 0, 1'b1, 8'd32, 4'd0, 1'b0, BG_C);
    wr(2, 127, 1'b0);
    pix(76, 0, 1'b1, 8'd127, 4'd0, 1'b0, BG_C);
    drain();

    // Asynchronous reset mid-glyph
    wr(0, 49, 1'b0);
    for (int i = 0; i < 3; i++) pix(12, 0, 1'b1, 8'd49, 4'd0, 1'b1, FG_C);
    for (int i = 0; i < 4; i++)
      drive(12, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 12'h0);
    chk("queues_drained", lq.size() + pq.size(), 0);
    @(posedge clk); #2;
    chk("lit_before_reset", int'(pixel_on), 1);
    rst_n = 1'b0;
    #1;
    chk("async_pixel_on", int'(pixel_on), 0);
    chk("async_rgb", int'(rgb), 0);
    chk("async_char_code", int'(char_code), 32);
    chk("async_row", int'(row), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_rgb1", int'(rgb), 0);
    chk("post_reset_code", int'(char_code), 32);
    @(negedge clk);
    chk("post_reset_rgb2", int'(rgb), 0);
    @(negedge clk);
    chk("post_reset_rgb3", int'(rgb), int'(BG_C));
    chk("post_reset_pixel_on", int'(pixel_on), 0);
    pix(12, 0, 1'b1, 8'd32, 4'd0, 1'b0, BG_C);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
